pong_match_ctrl: RTL

Match sequencer for the pong datapath; runs in the pixel clock domain next to the multiplayer game block. Takes the debounced start pulse, the game-mode switches, the per-frame refresh tick and the paddle-hit/miss events from the datapath. Produces the ball run/hold controls, serve direction, ball velocity and both player scores. Owns every rule about when play starts and stops, how points are scored, how speed escalates and when the match ends.

---
 rtl/pong_match_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong datapath: serve/play/point timing, scoring,
// velocity escalation and match end, all outputs registered.
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE     = 7,
    parameter int unsigned VEL_INIT      = 2,
    parameter int unsigned VEL_MAX       = 9,
    parameter int unsigned HITS_PER_STEP = 4,
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned POINT_FRAMES  = 90
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start_p,
    input  logic [1:0] mode,
    input  logic       frame_tick,
    input  logic       hit_p,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] vel,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] WIN_C      = 4'(WIN_SCORE);
    localparam logic [3:0] VEL_INIT_C = 4'(VEL_INIT);
    localparam logic [3:0] VEL_MAX_C  = 4'(VEL_MAX);
    localparam logic [3:0] HPS_C      = 4'(HITS_PER_STEP);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [3:0] hits_q, hits_d;
    logic [3:0] vel_q, vel_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic       run_q, run_d;
    logic       center_q, center_d;

    logic mode_off;
    logic miss_r_eff;

    assign mode_off   = (mode == 2'b00);
    // In single-player the right side is a wall, so a right miss cannot happen.
    assign miss_r_eff = miss_r && (mode != 2'b01);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_tick ? frame_q + 8'd1 : frame_q;
        hits_d    = hits_q;
        vel_d     = vel_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        dir_d     = dir_q;

        if (mode_off && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_p && !mode_off) begin
                        state_d   = SERVE;
                        score_l_d = '0;
                        score_r_d = '0;
                        winner_d  = 2'b00;
                        hits_d    = '0;
                        vel_d     = VEL_INIT_C;
                        dir_d     = 1'b0;
                    end
                end
                SERVE: begin
                    if (frame_tick && frame_q == SERVE_LAST) state_d = PLAY;
                end
                PLAY: begin
                    if (miss_l && miss_r_eff) begin
                        dir_d   = ~dir_q;
                        state_d = POINT;
                    end else if (miss_l) begin
                        score_r_d = score_r_q + 4'd1;
                        dir_d     = 1'b0;
                        state_d   = POINT;
                    end else if (miss_r_eff) begin
                        score_l_d = score_l_q + 4'd1;
                        dir_d     = 1'b1;
                        state_d   = POINT;
                    end else if (hit_p) begin
                        if (hits_q + 4'd1 == HPS_C) begin
                            hits_d = '0;
                            if (vel_q < VEL_MAX_C) vel_d = vel_q + 4'd1;
                        end else begin
                            hits_d = hits_q + 4'd1;
                        end
                    end
                end
                POINT: begin
                    if (frame_tick && frame_q == POINT_LAST) begin
                        if (score_l_q == WIN_C) begin
                            winner_d = 2'b01;
                            state_d  = OVER;
                        end else if (score_r_q == WIN_C) begin
                            winner_d = 2'b10;
                            state_d  = OVER;
                        end else begin
                            state_d = SERVE;
                            vel_d   = VEL_INIT_C;
                            hits_d  = '0;
                        end
                    end
                end
                OVER: begin
                    if (start_p) begin
                        state_d  = IDLE;
                        winner_d = 2'b00;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) frame_d = '0;

        run_d    = (state_d == PLAY);
        center_d = (state_d == IDLE) || (state_d == SERVE) || (state_d == OVER);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            hits_q    <= '0;
            vel_q     <= VEL_INIT_C;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            dir_q     <= 1'b0;
            run_q     <= 1'b0;
            center_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            hits_q    <= hits_d;
            vel_q     <= vel_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            dir_q     <= dir_d;
            run_q     <= run_d;
            center_q  <= center_d;
        end
    end

    assign ball_run    = run_q;
    assign ball_center = center_q;
    assign serve_dir   = dir_q;
    assign vel         = vel_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign winner      = winner_q;
    assign state_out   = state_q;

endmodule
